// File: rtl/nts_tx_streamer_pkg.sv
// Shared encodings and widths for the engine-side TX streamer.
package nts_tx_streamer_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_WRITING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_PRIME  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

endpackage

// File: rtl/nts_tx_streamer_ram.sv
// Two-bank packet RAM: one write port, one registered read port; bank select is the address MSB.
module nts_tx_streamer_ram
  import nts_tx_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [2**(ADDR_WIDTH+1)];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/nts_engine_tx_streamer.sv
// Ping-pong TX buffer read side: advertises committed packets and streams the oldest on request.
// Optional packet/drop/ignored-write counters are enabled by defining NTS_TX_STREAMER_COUNTERS_EN.
//   state     | meaning
//   RD_IDLE   | waiting for rd_start with a FULL bank
//   RD_PRIME  | RAM read latency, word 0 in flight
//   RD_STREAM | one valid word per cycle until the last
module nts_engine_tx_streamer
  import nts_tx_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  input  logic                  i_write_en,
  input  logic [ADDR_WIDTH-1:0] i_write_addr,
  input  logic [DATA_W-1:0]     i_write_data,
  input  logic                  i_update_length,
  input  logic [ADDR_WIDTH:0]   i_length_words,
  input  logic [2:0]            i_length_last_bytes,
  input  logic                  i_transfer,
  output logic                  o_write_ready,
  output logic                  o_packet_available,
  output logic                  o_fifo_empty,
  input  logic                  i_fifo_rd_start,
  output logic                  o_fifo_rd_valid,
  output logic [DATA_W-1:0]     o_fifo_rd_data,
  output logic                  o_fifo_rd_last,
`ifdef NTS_TX_STREAMER_COUNTERS_EN
  output logic [31:0]           o_cnt_packets_sent,
  output logic [31:0]           o_cnt_packets_dropped,
  output logic [31:0]           o_cnt_writes_ignored,
`endif
  output logic [2:0]            o_bytes_last_word
);

  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [1:0]            rst_sync;
  logic                  rst_b;
  bank_state_t           bank_st [2];
  logic [ADDR_WIDTH:0]   len [2];
  logic [2:0]            lbytes [2];
  logic                  wr_bank, rd_bank, newest;
  rd_state_t             state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   cnt, rd_len, last_idx, len_sat, len_eff;
  logic [2:0]            bytes_last;
  logic                  pkt_avail, fifo_empty;
  logic                  owned, full0, full1, any_full, oldest;
  logic                  commit, drop, start, stream_end, rd_en, valid;
  logic [DATA_W-1:0]     ram_q;

  // Assert asynchronously, release on the clock.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_b = rst_sync[1];

  // An EMPTY write bank is already the parser's; it is marked WRITING the next cycle.
  assign owned    = (bank_st[wr_bank] == BANK_EMPTY) || (bank_st[wr_bank] == BANK_WRITING);
  assign full0    = (bank_st[0] == BANK_FULL);
  assign full1    = (bank_st[1] == BANK_FULL);
  assign any_full = full0 || full1;
  assign oldest   = (full0 && full1) ? ~newest : full1;

  assign len_sat    = (i_length_words > MAX_LEN) ? MAX_LEN : i_length_words;
  assign len_eff    = i_update_length ? len_sat : len[wr_bank];
  assign commit     = i_transfer && owned;
  assign drop       = commit && (len_eff == '0);
  assign start      = (state == RD_IDLE) && i_fifo_rd_start && any_full;
  assign last_idx   = rd_len - 1'b1;
  assign stream_end = (state == RD_STREAM) && (cnt == last_idx);

  always_ff @(posedge i_clk or negedge rst_b) begin
    if (!rst_b) state <= RD_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    valid     = 1'b0;
    unique case (state)
      RD_IDLE:   if (start) state_nxt = RD_PRIME;
      RD_PRIME: begin
        rd_en     = 1'b1;
        state_nxt = RD_STREAM;
      end
      RD_STREAM: begin
        rd_en = 1'b1;
        valid = 1'b1;
        if (stream_end) state_nxt = RD_IDLE;
      end
      default:   state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_b) begin
    if (!rst_b) begin
      bank_st[0] <= BANK_EMPTY;
      bank_st[1] <= BANK_EMPTY;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (start && (oldest == 1'(b)))
          bank_st[b] <= BANK_READING;
        else if (stream_end && (rd_bank == 1'(b)))
          bank_st[b] <= BANK_EMPTY;
        else if (commit && (wr_bank == 1'(b)))
          bank_st[b] <= drop ? BANK_WRITING : BANK_FULL;
        else if ((wr_bank == 1'(b)) && (bank_st[b] == BANK_EMPTY))
          bank_st[b] <= BANK_WRITING;
      end
    end
  end

  always_ff @(posedge i_clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_bank   <= 1'b0;
      newest    <= 1'b0;
      len[0]    <= '0;
      len[1]    <= '0;
      lbytes[0] <= '0;
      lbytes[1] <= '0;
    end else if (commit) begin
      len[wr_bank] <= len_eff;
      if (i_update_length) lbytes[wr_bank] <= i_length_last_bytes;
      if (!drop) begin
        newest  <= wr_bank;
        wr_bank <= ~wr_bank;
      end
    end else if (i_update_length && owned) begin
      len[wr_bank]    <= len_sat;
      lbytes[wr_bank] <= i_length_last_bytes;
    end
  end

  always_ff @(posedge i_clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_bank    <= 1'b0;
      rd_len     <= '0;
      bytes_last <= '0;
      rd_addr    <= '0;
      cnt        <= '0;
      pkt_avail  <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      if (start) begin
        rd_bank    <= oldest;
        rd_len     <= len[oldest];
        bytes_last <= lbytes[oldest];
        rd_addr    <= '0;
        cnt        <= '0;
      end else begin
        if (rd_en)               rd_addr <= rd_addr + 1'b1;
        if (state == RD_STREAM)  cnt     <= cnt + 1'b1;
      end
      pkt_avail  <= any_full;
      fifo_empty <= !any_full && (bank_st[0] != BANK_READING) && (bank_st[1] != BANK_READING);
    end
  end

  nts_tx_streamer_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk     (i_clk),
    .rst_n   (rst_b),
    .wr_en   (i_write_en && owned),
    .wr_addr ({wr_bank, i_write_addr}),
    .wr_data (i_write_data),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank, rd_addr}),
    .rd_data (ram_q)
  );

  assign o_write_ready      = owned;
  assign o_packet_available = pkt_avail;
  assign o_fifo_empty       = fifo_empty;
  assign o_fifo_rd_valid    = valid;
  assign o_fifo_rd_data     = valid ? ram_q : '0;
  assign o_fifo_rd_last     = valid && (cnt == last_idx);
  assign o_bytes_last_word  = bytes_last;

`ifdef NTS_TX_STREAMER_COUNTERS_EN
  always_ff @(posedge i_clk or negedge rst_b) begin
    if (!rst_b) begin
      o_cnt_packets_sent    <= '0;
      o_cnt_packets_dropped <= '0;
      o_cnt_writes_ignored  <= '0;
    end else begin
      if (o_fifo_rd_last)           o_cnt_packets_sent    <= o_cnt_packets_sent + 1'b1;
      if (drop)                     o_cnt_packets_dropped <= o_cnt_packets_dropped + 1'b1;
      if (i_write_en && !owned)     o_cnt_writes_ignored  <= o_cnt_writes_ignored + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nts_engine_tx_streamer.sv
// Scoreboard bench for nts_engine_tx_streamer: directed packets, words checked by a negedge monitor.
module tb_nts_engine_tx_streamer;
  localparam int AW = 8;

  logic          i_clk = 1'b0;
  logic          i_areset_n;
  logic          i_write_en;
  logic [AW-1:0] i_write_addr;
  logic [63:0]   i_write_data;
  logic          i_update_length;
  logic [AW:0]   i_length_words;
  logic [2:0]    i_length_last_bytes;
  logic          i_transfer;
  logic          o_write_ready;
  logic          o_packet_available;
  logic          o_fifo_empty;
  logic          i_fifo_rd_start;
  logic          o_fifo_rd_valid;
  logic [63:0]   o_fifo_rd_data;
  logic          o_fifo_rd_last;
  logic [2:0]    o_bytes_last_word;
`ifdef NTS_TX_STREAMER_COUNTERS_EN
  logic [31:0]   o_cnt_packets_sent;
  logic [31:0]   o_cnt_packets_dropped;
  logic [31:0]   o_cnt_writes_ignored;
`endif

  int total = 0;
  int bad = 0;
  logic [64:0] sb [$];
  logic [64:0] exp_w;

  localparam logic [63:0] A_BASE = 64'hAAAA_0000_0000_0000;
  localparam logic [63:0] B_BASE = 64'hBBBB_0000_0000_0000;
  localparam logic [63:0] C_BASE = 64'hC0C0_0000_0000_0000;
  localparam logic [63:0] D_BASE = 64'hD0D0_0000_0000_0000;
  localparam logic [63:0] E_BASE = 64'hEEEE_0000_0000_0000;

  always #5 i_clk = ~i_clk;

  nts_engine_tx_streamer #(.ADDR_WIDTH(AW)) dut (
    .i_clk               (i_clk),
    .i_areset_n          (i_areset_n),
    .i_write_en          (i_write_en),
    .i_write_addr        (i_write_addr),
    .i_write_data        (i_write_data),
    .i_update_length     (i_update_length),
    .i_length_words      (i_length_words),
    .i_length_last_bytes (i_length_last_bytes),
    .i_transfer          (i_transfer),
    .o_write_ready       (o_write_ready),
    .o_packet_available  (o_packet_available),
    .o_fifo_empty        (o_fifo_empty),
    .i_fifo_rd_start     (i_fifo_rd_start),
    .o_fifo_rd_valid     (o_fifo_rd_valid),
    .o_fifo_rd_data      (o_fifo_rd_data),
    .o_fifo_rd_last      (o_fifo_rd_last),
`ifdef NTS_TX_STREAMER_COUNTERS_EN
    .o_cnt_packets_sent    (o_cnt_packets_sent),
    .o_cnt_packets_dropped (o_cnt_packets_dropped),
    .o_cnt_writes_ignored  (o_cnt_writes_ignored),
`endif
    .o_bytes_last_word   (o_bytes_last_word)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented word must be the next expected one.
  always @(negedge i_clk) begin
    if (o_fifo_rd_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL rd_word: got %h last=%0b expected no word", o_fifo_rd_data, o_fifo_rd_last);
      end else begin
        exp_w = sb.pop_front();
        if ({o_fifo_rd_last, o_fifo_rd_data} !== exp_w) begin
          bad++;
          $display("FAIL rd_word: got %h last=%0b expected %h last=%0b",
                   o_fifo_rd_data, o_fifo_rd_last, exp_w[63:0], exp_w[64]);
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [63:0] d);
    i_write_en = 1'b1; i_write_addr = a; i_write_data = d;
    cyc();
    i_write_en = 1'b0;
  endtask

  task automatic commit(input logic [AW:0] len, input logic [2:0] lb);
    i_update_length = 1'b1; i_length_words = len; i_length_last_bytes = lb;
    cyc();
    i_update_length = 1'b0;
    i_transfer = 1'b1;
    cyc();
    i_transfer = 1'b0;
  endtask

  task automatic load(input int n, input logic [63:0] base, input logic [AW:0] len, input logic [2:0] lb);
    for (int i = 0; i < n; i++) wr(AW'(i), base | 64'(i));
    commit(len, lb);
  endtask

  task automatic expect_pkt(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) sb.push_back({(i == n - 1), base | 64'(i)});
  endtask

  task automatic rd_pulse();
    i_fifo_rd_start = 1'b1;
    cyc();
    i_fifo_rd_start = 1'b0;
  endtask

  initial begin
    i_areset_n = 1'b0; i_write_en = 1'b0; i_write_addr = '0; i_write_data = '0;
    i_update_length = 1'b0; i_length_words = '0; i_length_last_bytes = '0;
    i_transfer = 1'b0; i_fifo_rd_start = 1'b0;
    cyc(3);
    i_areset_n = 1'b1;
    cyc(4);
    check("rst_ready", 64'(o_write_ready), 64'd1);
    check("rst_avail", 64'(o_packet_available), 64'd0);
    check("rst_empty", 64'(o_fifo_empty), 64'd1);
    check("rst_valid", 64'(o_fifo_rd_valid), 64'd0);
    check("rst_data", o_fifo_rd_data, 64'd0);
    check("rst_bytes", 64'(o_bytes_last_word), 64'd0);

    // three-word packet
    wr(8'd0, 64'h1111_1111_1111_1111);
    wr(8'd1, 64'h2222_2222_2222_2222);
    wr(8'd2, 64'h3333_3333_3333_3333);
    commit(9'd3, 3'd4);
    cyc(2);
    check("t1_avail", 64'(o_packet_available), 64'd1);
    check("t1_empty", 64'(o_fifo_empty), 64'd0);
    check("t1_ready", 64'(o_write_ready), 64'd1);
    sb.push_back({1'b0, 64'h1111_1111_1111_1111});
    sb.push_back({1'b0, 64'h2222_2222_2222_2222});
    sb.push_back({1'b1, 64'h3333_3333_3333_3333});
    rd_pulse();
    check("t1_bytes", 64'(o_bytes_last_word), 64'd4);
    check("t1_prime_valid", 64'(o_fifo_rd_valid), 64'd0);
    cyc();
    check("t1_first_valid", 64'(o_fifo_rd_valid), 64'd1);
    cyc(6);
    check("t1_words_left", 64'(sb.size()), 64'd0);
    check("t1_empty_after", 64'(o_fifo_empty), 64'd1);
    check("t1_avail_after", 64'(o_packet_available), 64'd0);

    // back-to-back A then B, write bank stalls
    load(2, A_BASE, 9'd2, 3'd3);
    check("t2_ready_after_a", 64'(o_write_ready), 64'd1);
    load(5, B_BASE, 9'd5, 3'd7);
    check("t2_ready_after_b", 64'(o_write_ready), 64'd0);
    wr(8'd0, 64'hDEAD_BEEF_DEAD_BEEF);
    check("t2_avail", 64'(o_packet_available), 64'd1);
    expect_pkt(2, A_BASE);
    rd_pulse();
    check("t2_a_bytes", 64'(o_bytes_last_word), 64'd3);
    cyc(2);
    check("t2_ready_on_last", 64'(o_write_ready), 64'd0);
    cyc();
    check("t2_ready_returns", 64'(o_write_ready), 64'd1);
    check("t2_a_done_valid", 64'(o_fifo_rd_valid), 64'd0);
    check("t2_a_words_left", 64'(sb.size()), 64'd0);
    expect_pkt(5, B_BASE);
    rd_pulse();
    check("t2_b_bytes", 64'(o_bytes_last_word), 64'd7);
    cyc();
    rd_pulse();
    cyc(8);
    check("t2_b_words_left", 64'(sb.size()), 64'd0);
    check("t2_b_empty", 64'(o_fifo_empty), 64'd1);
    check("t2_b_bytes_held", 64'(o_bytes_last_word), 64'd7);

    // rd_start with nothing committed
    rd_pulse();
    cyc(4);
    check("t2_idle_bytes", 64'(o_bytes_last_word), 64'd7);
    check("t2_idle_empty", 64'(o_fifo_empty), 64'd1);
    check("t2_idle_valid", 64'(o_fifo_rd_valid), 64'd0);

    // zero length is dropped
    wr(8'd0, 64'h0123_4567_89AB_CDEF);
    commit(9'd0, 3'd0);
    cyc(2);
    check("t3_avail", 64'(o_packet_available), 64'd0);
    check("t3_ready", 64'(o_write_ready), 64'd1);
    check("t3_empty", 64'(o_fifo_empty), 64'd1);
`ifdef NTS_TX_STREAMER_COUNTERS_EN
    check("t3_cnt_dropped", 64'(o_cnt_packets_dropped), 64'd1);
    check("t3_cnt_sent", 64'(o_cnt_packets_sent), 64'd3);
    check("t3_cnt_ignored", 64'(o_cnt_writes_ignored), 64'd1);
`endif

    // full-bank packet, then an over-long length that must saturate
    load(256, C_BASE, 9'd256, 3'd5);
    check("t4_ready_c", 64'(o_write_ready), 64'd1);
    load(256, D_BASE, 9'd400, 3'd0);
    check("t4_ready_d", 64'(o_write_ready), 64'd0);
    expect_pkt(256, C_BASE);
    rd_pulse();
    check("t4_c_bytes", 64'(o_bytes_last_word), 64'd5);
    cyc(262);
    check("t4_c_words_left", 64'(sb.size()), 64'd0);
    expect_pkt(256, D_BASE);
    rd_pulse();
    check("t4_d_bytes", 64'(o_bytes_last_word), 64'd0);
    cyc(262);
    check("t4_d_words_left", 64'(sb.size()), 64'd0);
    check("t4_empty", 64'(o_fifo_empty), 64'd1);

    // reset in the middle of a five-word stream
    load(5, E_BASE, 9'd5, 3'd2);
    expect_pkt(5, E_BASE);
    rd_pulse();
    cyc(3);
    check("t5_valid_word2", 64'(o_fifo_rd_valid), 64'd1);
    #2 i_areset_n = 1'b0;
    #1;
    check("t5_valid_drop", 64'(o_fifo_rd_valid), 64'd0);
    check("t5_data_drop", o_fifo_rd_data, 64'd0);
    cyc(3);
    check("t5_words_before_reset", 64'(sb.size()), 64'd3);
    sb.delete();
    i_areset_n = 1'b1;
    cyc(4);
    check("t5_ready", 64'(o_write_ready), 64'd1);
    check("t5_avail", 64'(o_packet_available), 64'd0);
    check("t5_empty", 64'(o_fifo_empty), 64'd1);
    check("t5_valid", 64'(o_fifo_rd_valid), 64'd0);
    check("t5_last", 64'(o_fifo_rd_last), 64'd0);
    check("t5_data", o_fifo_rd_data, 64'd0);
    check("t5_bytes", 64'(o_bytes_last_word), 64'd0);
    rd_pulse();
    cyc(4);
    check("t5_post_rd_empty", 64'(o_fifo_empty), 64'd1);
    check("t5_post_rd_valid", 64'(o_fifo_rd_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
